fast_adder_pipe: RTL
====================

# fast_adder_pipe

Pipelined, parametrised successor to the single-cycle carry-lookahead adder. Splits an N-bit add/subtract into CHUNKS lookahead chunks of WIDTH bits, one chunk per pipeline stage, with registered inter-stage carry and skewed operand buffering. It accepts one operation per cycle under a valid/ready handshake. It sits between the ALU operand latches and the accumulator write-back path, and returns the sum, carry, signed overflow, zero and word-level propagate/generate.

## Interface
- WIDTH, 4: bits per lookahead chunk; ≥1.
- CHUNKS, 4: number of chunks and pipeline stages; ≥1. N = WIDTH*CHUNKS.
- clk_in  input  1  clock; all state updates on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- in_valid_in  input  1  operand beat valid.
- in_ready_out  output  1  block can accept a beat this cycle.
- a_in  input  N  operand A.
- b_in  input  N  operand B.
- c_in  input  1  carry-in (add) / borrow-in (subtract).
- sub_in  input  1  1 = A − B, 0 = A + B.
- out_valid_out  output  1  result beat valid.
- out_ready_in  input  1  consumer accepts result.
- sum_out  output  N  result.
- carry_out  output  1  carry out of bit N−1.
- overflow_out  output  1  two's-complement overflow.
- zero_out  output  1  sum_out == 0.
- pg_out  output  1  word propagate: AND of all bit propagates.
- gg_out  output  1  word generate, independent of carry-in.

## Operation
- Effective operands: B' = sub ? ~B : B; cin' = sub ? ~c_in : c_in. Subtract with c_in=0 gives A − B; c_in=1 gives A − B − 1.
- Stage k (0..CHUNKS−1) adds chunk k of A and B' with carry-lookahead inside the chunk. It registers the chunk sum, the chunk carry for stage k+1, and the running pg/gg. Upper chunks of A and B' travel through per-stage skew registers. Lower sum chunks travel through de-skew registers.
- Bit propagate p_i = A_i ^ B'_i; generate g_i = A_i & B'_i. pg_out = &p. gg_out = group generate of the whole word with carry-in forced to 0.
- carry_out = final chunk carry = gg | (pg & cin'). Subtract reports raw carry, so 1 means no borrow.
- overflow_out = (A[N−1] == B'[N−1]) && (sum[N−1] != A[N−1]).
- All arithmetic is modulo 2^N. No saturation.
- Handshake: a beat is accepted when in_valid_in && in_ready_out. A result is consumed when out_valid_out && out_ready_in.
- Global stall: in_ready_out = !reset_in && (!out_valid_out || out_ready_in). When it is 0, every stage register and valid bit holds.
- Bubbles are not compressed. Each stage carries a valid bit and shifts whenever in_ready_out = 1.
- Results always leave in issue order.

## Timing
- Latency: exactly CHUNKS cycles from the accepting edge to out_valid_out = 1, with no stalls.
- Throughput: one operation per cycle while out_ready_in = 1.
- A stall of S cycles adds S cycles to every in-flight beat.
- Output payload is registered and stays stable while out_valid_out && !out_ready_in.
- Simultaneous accept and consume in one cycle is allowed and loses nothing.
- Reset values, visible on the cycle after reset_in is sampled high: all valid bits 0; sum_out, carry_out, overflow_out, zero_out, pg_out, gg_out all 0. in_ready_out is 0 while reset_in = 1 and 1 on the first cycle after.
- Reset mid-operation discards every in-flight beat. No partial result is emitted.
- CHUNKS = 1 degenerates to a single registered lookahead adder with latency 1.

## Configuration
- FAST_ADDER_PIPE_SUB_EN defined: sub_in is honoured as specified.
- Not defined: sub_in is ignored and the block is add-only, with B' = B and cin' = c_in. The B inversion muxes are not synthesised. overflow_out still uses the add rule.

## Test plan
Bench uses WIDTH=2, CHUNKS=2 (N=4, latency 2), with FAST_ADDER_PIPE_SUB_EN defined unless noted.
- Reset, then A=1000, B=1000, c=1, add → 2 cycles later: sum=0001, carry=1, overflow=1, pg=0, gg=1, zero=0.
- A=0101, B=1010, c=0, add → sum=1111, pg=1, gg=0, carry=0. Same operands with c=1 → sum=0000, carry=1, zero=1.
- Subtract A=0011, B=0101, c=0 → sum=1110, carry=0, overflow=0. Subtract A=1000, B=0001 → sum=0111, overflow=1, carry=1.
- Back-to-back beats 0001+0001, 0010+0010, 0011+0011 → results 0010, 0100, 0110 on consecutive cycles. Hold out_ready_in low for 3 cycles mid-stream → output stable, in_ready_out=0, no loss or reorder.
- Assert reset_in with 2 beats in flight → no out_valid_out afterwards, all outputs 0. A new beat issued after reset returns after exactly 2 cycles.
- Without FAST_ADDER_PIPE_SUB_EN: sub_in=1, A=0011, B=0101, c=0 → sum=1000, treated as an add.

Source files
------------

// File: rtl/fast_adder_pipe.sv
// fast_adder_pipe: pipelined carry-lookahead adder/subtractor.
// The N = WIDTH*CHUNKS bit word is split into CHUNKS lookahead chunks, one per
// pipeline stage. Each stage registers its chunk sum, the carry into the next
// chunk, and the running word propagate/generate. Operands ride along in skew
// registers and finished sum chunks ride along in de-skew registers. As a
// result, all fields of one operation leave the last stage together.
//
// Build option: FAST_ADDER_PIPE_SUB_EN -- when defined, sub_in selects A - B
// (B inverted, carry-in inverted). When undefined, the block is add-only and
// sub_in is ignored.
//
// Handshake: a beat is accepted on a rising edge where in_valid_in && in_ready_out;
// a result is consumed on a rising edge where out_valid_out && out_ready_in.
// in_ready_out is also the global advance enable: when it is low, every stage
// register and valid bit holds, so results keep issue order and stay stable.
module fast_adder_pipe #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      in_valid_in,
    output logic                      in_ready_out,
    input  logic [WIDTH*CHUNKS-1:0]   a_in,
    input  logic [WIDTH*CHUNKS-1:0]   b_in,
    input  logic                      c_in,
    input  logic                      sub_in,
    output logic                      out_valid_out,
    input  logic                      out_ready_in,
    output logic [WIDTH*CHUNKS-1:0]   sum_out,
    output logic                      carry_out,
    output logic                      overflow_out,
    output logic                      zero_out,
    output logic                      pg_out,
    output logic                      gg_out
);
    localparam int N = WIDTH * CHUNKS;

    // Effective operands after the optional subtract inversion.
    logic [N-1:0] b_eff;
    logic         cin_eff;

`ifdef FAST_ADDER_PIPE_SUB_EN
    assign b_eff   = sub_in ? ~b_in : b_in;
    assign cin_eff = sub_in ? ~c_in : c_in;
`else
    logic unused_sub;
    assign unused_sub = sub_in;
    assign b_eff      = b_in;
    assign cin_eff    = c_in;
`endif

    // Per-stage registers: valid, operand skew, sum de-skew, chunk carry, pg/gg.
    logic         v_q   [CHUNKS];
    logic [N-1:0] a_q   [CHUNKS];
    logic [N-1:0] b_q   [CHUNKS];
    logic [N-1:0] sum_q [CHUNKS];
    logic         c_q   [CHUNKS];
    logic         pg_q  [CHUNKS];
    logic         gg_q  [CHUNKS];
    logic         zero_q;
    logic         ovf_q;

    // Next values for every stage.
    logic         v_d   [CHUNKS];
    logic [N-1:0] a_d   [CHUNKS];
    logic [N-1:0] b_d   [CHUNKS];
    logic [N-1:0] sum_d [CHUNKS];
    logic         c_d   [CHUNKS];
    logic         pg_d  [CHUNKS];
    logic         gg_d  [CHUNKS];
    logic         zero_d;
    logic         ovf_d;

    // Scratch used while evaluating one stage.
    logic         st_v;
    logic [N-1:0] st_a;
    logic [N-1:0] st_b;
    logic [N-1:0] st_sum;
    logic         st_cin;
    logic         st_pg;
    logic         st_gg;
    logic         grp_g;
    logic         grp_p;
    logic         bit_p;
    logic         bit_g;

    assign in_ready_out = !reset_in && (!v_q[CHUNKS-1] || out_ready_in);

    // Evaluate each stage: lookahead add of chunk s on the data entering stage s.
    always_comb begin
        st_v   = 1'b0;
        st_a   = '0;
        st_b   = '0;
        st_sum = '0;
        st_cin = 1'b0;
        st_pg  = 1'b0;
        st_gg  = 1'b0;
        grp_g  = 1'b0;
        grp_p  = 1'b0;
        bit_p  = 1'b0;
        bit_g  = 1'b0;
        for (int s = 0; s < CHUNKS; s++) begin
            if (s == 0) begin
                st_v   = in_valid_in;
                st_a   = a_in;
                st_b   = b_eff;
                st_sum = '0;
                st_cin = cin_eff;
                st_pg  = 1'b1;
                st_gg  = 1'b0;
            end else begin
                st_v   = v_q[s-1];
                st_a   = a_q[s-1];
                st_b   = b_q[s-1];
                st_sum = sum_q[s-1];
                st_cin = c_q[s-1];
                st_pg  = pg_q[s-1];
                st_gg  = gg_q[s-1];
            end
            // The group generate/propagate prefix uses only bits below i, so
            // every bit carry is G[i-1:0] | P[i-1:0] & cin (lookahead form).
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                bit_p = st_a[s*WIDTH+i] ^ st_b[s*WIDTH+i];
                bit_g = st_a[s*WIDTH+i] & st_b[s*WIDTH+i];
                st_sum[s*WIDTH+i] = bit_p ^ (grp_g | (grp_p & st_cin));
                grp_g = bit_g | (bit_p & grp_g);
                grp_p = grp_p & bit_p;
            end
            v_d[s]   = st_v;
            a_d[s]   = st_a;
            b_d[s]   = st_b;
            sum_d[s] = st_sum;
            c_d[s]   = grp_g | (grp_p & st_cin);
            pg_d[s]  = st_pg & grp_p;
            // Running word generate ignores the carry-in entirely.
            gg_d[s]  = grp_g | (grp_p & st_gg);
        end
        zero_d = (sum_d[CHUNKS-1] == '0);
        ovf_d  = (a_d[CHUNKS-1][N-1] == b_d[CHUNKS-1][N-1]) &&
                 (sum_d[CHUNKS-1][N-1] != a_d[CHUNKS-1][N-1]);
    end

    // Shift every stage together when the pipe may advance; clear all on reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int s = 0; s < CHUNKS; s++) begin
                v_q[s]   <= 1'b0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
                c_q[s]   <= 1'b0;
                pg_q[s]  <= 1'b0;
                gg_q[s]  <= 1'b0;
            end
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (in_ready_out) begin
            for (int s = 0; s < CHUNKS; s++) begin
                v_q[s]   <= v_d[s];
                a_q[s]   <= a_d[s];
                b_q[s]   <= b_d[s];
                sum_q[s] <= sum_d[s];
                c_q[s]   <= c_d[s];
                pg_q[s]  <= pg_d[s];
                gg_q[s]  <= gg_d[s];
            end
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid_out = v_q[CHUNKS-1];
    assign sum_out       = sum_q[CHUNKS-1];
    assign carry_out     = c_q[CHUNKS-1];
    assign pg_out        = pg_q[CHUNKS-1];
    assign gg_out        = gg_q[CHUNKS-1];
    assign zero_out      = zero_q;
    assign overflow_out  = ovf_q;

endmodule
